// File: rtl/mux_2x1_rr_ctrl.sv
// Round-robin burst arbiter sharing one 2:1 datapath mux between two requesters,
// with a one-entry registered output stage and valid/ready handshake.
module mux_2x1_rr_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int COMMMAND_WIDTH = 1,
    parameter int BURST_WIDTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                i_valid,
    input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
    output logic [1:0]                o_ready,
    input  logic [BURST_WIDTH-1:0]    i_burst_len,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_data_bus,
    input  logic                      i_ready,
    output logic                      o_en,
    output logic [COMMMAND_WIDTH-1:0] o_cmd
);

    // state      | meaning
    // IDLE       | no grant; arbitrating between pending requests
    // GRANT_LOW  | low branch owns the mux for up to burst_q beats
    // GRANT_HIGH | high branch owns the mux for up to burst_q beats
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_LOW  = 2'd1,
        GRANT_HIGH = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    last_grant;   // 1 = high branch was granted last
    logic                    new_grant;
    logic [BURST_WIDTH-1:0]  beat_cnt;
    logic [BURST_WIDTH-1:0]  burst_q;
    logic                    can_load;
    logic                    xfer;
    logic                    last_beat;
    logic [DATA_WIDTH-1:0]   sel_data;

    assign can_load   = !o_valid || i_ready;
    assign o_ready[0] = (state == GRANT_LOW)  && can_load;
    assign o_ready[1] = (state == GRANT_HIGH) && can_load;
    assign xfer       = |(i_valid & o_ready);
    assign last_beat  = (beat_cnt == burst_q - BURST_WIDTH'(1));

    assign sel_data = (state == GRANT_HIGH) ? i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]
                                            : i_data_bus[DATA_WIDTH-1:0];

    assign o_en  = (state != IDLE);
    assign o_cmd = COMMMAND_WIDTH'(state == GRANT_HIGH);

    // Release re-arbitrates in the same edge so back-to-back bursts have no bubble.
    always_comb begin
        state_nxt = state;
        new_grant = 1'b0;
        case (state)
            IDLE: begin
                case (i_valid)
                    2'b01: begin
                        state_nxt = GRANT_LOW;
                        new_grant = 1'b1;
                    end
                    2'b10: begin
                        state_nxt = GRANT_HIGH;
                        new_grant = 1'b1;
                    end
                    2'b11: begin
                        state_nxt = last_grant ? GRANT_LOW : GRANT_HIGH;
                        new_grant = 1'b1;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
            GRANT_LOW: begin
                if (!i_valid[0] || (xfer && last_beat)) begin
                    if (i_valid[1]) begin
                        state_nxt = GRANT_HIGH;
                        new_grant = 1'b1;
                    end else if (i_valid[0]) begin
                        state_nxt = GRANT_LOW;
                        new_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GRANT_HIGH: begin
                if (!i_valid[1] || (xfer && last_beat)) begin
                    if (i_valid[0]) begin
                        state_nxt = GRANT_LOW;
                        new_grant = 1'b1;
                    end else if (i_valid[1]) begin
                        state_nxt = GRANT_HIGH;
                        new_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            burst_q    <= BURST_WIDTH'(1);
        end else begin
            state <= state_nxt;
            if (new_grant) begin
                beat_cnt   <= '0;
                burst_q    <= (i_burst_len == '0) ? BURST_WIDTH'(1) : i_burst_len;
                last_grant <= (state_nxt == GRANT_HIGH);
            end else if (xfer) begin
                beat_cnt <= beat_cnt + BURST_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
        end else if (xfer) begin
            o_valid    <= 1'b1;
            o_data_bus <= sel_data;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
